// File: rtl/regfile_scoreboard.sv
// NREGS x XLEN register file with hardwired zero register, optional write-to-read
// bypass, per-register busy scoreboard and a sequential clear engine.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            CLR_REQ,
  input  logic            ST_REG,
  input  logic [AW-1:0]   DR,
  input  logic [XLEN-1:0] WB_DATA,
  input  logic [AW-1:0]   SR1,
  input  logic [AW-1:0]   SR2,
  output logic [XLEN-1:0] out_one,
  output logic [XLEN-1:0] out_two,
  input  logic            ISSUE_V,
  input  logic [AW-1:0]   ISSUE_DR,
  input  logic            FLUSH,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_next;
  logic [AW-1:0]   cnt;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [XLEN-1:0] mem [NREGS];

  logic run;
  logic wr_en;
  logic fwd1;
  logic fwd2;
  logic zero1;
  logic zero2;

  assign run   = (state == RUN);
  assign ready = run;

  // State register
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_next;
  end

  // Next-state logic: clear walks every index once, then runs until a clear request
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (cnt == AW'(NREGS - 1)) state_next = RUN;
      RUN:     if (CLR_REQ) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  // Clear index counter; wraps to zero naturally since NREGS is a power of two
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)     cnt <= '0;
    else if (!run)    cnt <= cnt + AW'(1);
    else if (CLR_REQ) cnt <= '0;
  end

  // Writes arriving with a clear request are dropped
  assign wr_en = run && ST_REG && !CLR_REQ && !(ZERO_REG && (DR == '0));

  // Storage has no reset; the clear engine zeroes it
  always_ff @(posedge CLK) begin
    if (!run)       mem[cnt] <= '0;
    else if (wr_en) mem[DR]  <= WB_DATA;
  end

  // Scoreboard: flush/clear beats issue, issue beats same-index writeback
  always_comb begin
    busy_next = busy;
    if (!run || CLR_REQ || FLUSH) begin
      busy_next = '0;
    end else begin
      if (ST_REG) busy_next[DR] = 1'b0;
      if (ISSUE_V && !(ZERO_REG && (ISSUE_DR == '0))) busy_next[ISSUE_DR] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_next;
  end

  // Read ports
  assign zero1 = ZERO_REG && (SR1 == '0);
  assign zero2 = ZERO_REG && (SR2 == '0);
  assign fwd1  = BYPASS && ST_REG && run && (DR == SR1);
  assign fwd2  = BYPASS && ST_REG && run && (DR == SR2);

  assign out_one = (!run || zero1) ? '0 : (fwd1 ? WB_DATA : mem[SR1]);
  assign out_two = (!run || zero2) ? '0 : (fwd2 ? WB_DATA : mem[SR2]);

  // A forwarded operand is never reported busy
  assign busy1 = run && !fwd1 && busy[SR1];
  assign busy2 = run && !fwd2 && busy[SR2];

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's integer register file: NREGS x XLEN storage, two combinational read ports and one write port.
- Adds a hardwired-zero register, an optional write-to-read bypass and a per-register busy scoreboard for decode-stage hazard detection.
- Adds a sequential clear engine that zeroes the array after reset or on request.
- Sits between decode (reads, issue) and writeback (writes) in the pipeline.

Parameters:
- XLEN, 64, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(NREGS), register index width.
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to read ports.
- ZERO_REG, 1, 1 = register 0 reads zero and ignores writes and issues.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- CLR_REQ  input  1  synchronous request to re-run the clear sequence.
- ST_REG  input  1  writeback enable.
- DR  input  AW  writeback destination index.
- WB_DATA  input  XLEN  writeback data.
- SR1  input  AW  read port 1 index.
- SR2  input  AW  read port 2 index.
- out_one  output  XLEN  read data for SR1.
- out_two  output  XLEN  read data for SR2.
- ISSUE_V  input  1  decode issued an instruction that will write ISSUE_DR.
- ISSUE_DR  input  AW  destination index of the issued instruction.
- FLUSH  input  1  pipeline flush; clears all busy bits.
- busy1  output  1  SR1 has an outstanding producer.
- busy2  output  1  SR2 has an outstanding producer.
- ready  output  1  clear sequence done; block accepts ST_REG and ISSUE_V.

Behaviour:
- FSM states: CLEAR and RUN.
  - reset_n low (async): state=CLEAR, clear counter=0, busy vector=0, ready=0.
  - The storage array is not async-reset; it is zeroed by the clear engine.
- CLEAR state:
  - Each cycle writes zero to regFile[counter], then increments the counter.
  - After writing index NREGS-1, the next state is RUN; CLEAR lasts exactly NREGS cycles after reset_n rises.
  - During CLEAR: ready=0, ST_REG and ISSUE_V are ignored, out_one, out_two, busy1 and busy2 read 0.
- RUN state: ready=1.
  - CLR_REQ=1 moves to CLEAR on the next edge: counter=0, busy vector cleared, ready=0 from that edge.
  - A write presented in the same cycle as CLR_REQ is dropped.
- Write: in RUN, if ST_REG and not (ZERO_REG and DR==0), regFile[DR] <= WB_DATA at the edge.
- Reads (combinational):
  - out_x = 0 if ZERO_REG and SRx==0.
  - Otherwise WB_DATA if BYPASS and ST_REG and ready and DR==SRx.
  - Otherwise regFile[SRx].
- Scoreboard, one bit per register, next-state priority per index i:
  1. FLUSH: busy[i]=0, overrides issue.
  2. ISSUE_V and ISSUE_DR==i: busy[i]=1. A newer producer wins over a simultaneous writeback to the same index.
  3. ST_REG and DR==i: busy[i]=0.
  4. Otherwise busy[i] holds.
  - Index 0 is never set when ZERO_REG=1.
  - Issue and writeback are ignored while ready=0.
- busy outputs: busyx = busy[SRx], forced 0 when BYPASS and ST_REG and ready and DR==SRx, since data is forwarded that cycle.
- Multiple ST_REG writes to the same index in consecutive cycles: last write wins; no write-merge.
- Width rule: WB_DATA is stored unmodified. Indices are exactly AW bits, so there is no out-of-range case.

Test Plan:
- Reset: drop reset_n mid-run for 1 cycle, then release -> ready=0 for exactly 32 cycles, then 1. All 32 registers read 0; busy1=busy2=0.
- Write/read/bypass: ST_REG, DR=5, WB_DATA=0xDEADBEEF_00000001, SR1=5 -> out_one=0xDEADBEEF_00000001 in the same cycle (BYPASS=1) and after the edge. With BYPASS=0, out_one=0 in the write cycle and the written value after the edge.
- Zero register: ST_REG DR=0 WB_DATA=0xFFFF..., ISSUE_V ISSUE_DR=0 -> out_one(SR1=0)=0 and busy1=0 in all following cycles.
- Scoreboard:
  - ISSUE_V DR=7 -> busy1(SR1=7)=1 next cycle.
  - Writeback DR=7 -> busy1=0 in the writeback cycle and after.
  - ISSUE_V DR=7 together with ST_REG DR=7 -> busy stays 1.
  - FLUSH together with ISSUE_V DR=9 -> busy[9]=0.
- Soft clear: write 0x1234 to register 12, pulse CLR_REQ with ST_REG DR=13 -> ready=0 for 32 cycles, register 13 not written, then registers 12 and 13 read 0.
- Parametrised build: XLEN=32, NREGS=16, ZERO_REG=0 -> clear lasts 16 cycles. Register 0 is writable: write 0xA5A5A5A5, read back 0xA5A5A5A5.
